shift_arbiter: RTL and testbench

Two-requester arbiter and result buffer for the shared 64-bit logical-right shifter in the execute stage. Grants one request per cycle round-robin, drives a single LSR_64 instance (shift amount on its 6-bit enable vector), registers the result and returns it tagged with the granted port under a valid/ready handshake. Requester 0 is the ALU shift path; requester 1 is the address-generation path.

---
 rtl/shift_arbiter.sv | 122 ++++++++++++
 tb/tb_shift_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin front end for the shared 64-bit logical-right
// shifter, with a one-entry result register behind a valid/ready handshake.
// Port 0 is the ALU shift path, port 1 is the address-generation path.

// LSR_64: six-stage logarithmic right shifter. Stage k shifts by 2^k when
// enable[k] is set, so enable is simply the binary shift amount.
module LSR_64 (
    input  logic [63:0] in,
    input  logic [5:0]  enable,
    output logic [63:0] out
);
    logic [6:0][63:0] stage;

    assign stage[0] = in;

    for (genvar k = 0; k < 6; k++) begin : g_stage
        localparam int SH = 1 << k;
        // Zero-filling shift by a fixed power of two, bypassed when the bit is clear.
        assign stage[k+1] = enable[k] ? (stage[k] >> SH) : stage[k];
    end

    assign out = stage[6];
endmodule

module shift_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [63:0] req0_data,
    input  logic [5:0]  req0_shamt,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [63:0] req1_data,
    input  logic [5:0]  req1_shamt,
    output logic        req1_ready,
    output logic        rsp_valid,
    output logic [63:0] rsp_data,
    output logic        rsp_port,
    input  logic        rsp_ready
);
    logic        rsp_valid_q, rsp_valid_d;
    logic [63:0] rsp_data_q,  rsp_data_d;
    logic        rsp_port_q,  rsp_port_d;
    logic        prio_q,      prio_d;

    logic        can_issue;
    logic        gnt_vld;
    logic        gnt_port;
    logic [63:0] sh_in;
    logic [5:0]  sh_amt;
    logic [63:0] sh_out;

    // The result slot is free if empty or being drained this very cycle.
    assign can_issue = !rsp_valid_q || rsp_ready;

    // Grant selection: a lone requester always wins; a tie goes to prio.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_port = 1'b0;
        if (can_issue) begin
            if (req0_valid && req1_valid) begin
                gnt_vld  = 1'b1;
                gnt_port = prio_q;
            end else if (req0_valid) begin
                gnt_vld  = 1'b1;
                gnt_port = 1'b0;
            end else if (req1_valid) begin
                gnt_vld  = 1'b1;
                gnt_port = 1'b1;
            end
        end
    end

    // Readys are forced low while reset is held so nothing is accepted then.
    assign req0_ready = !reset && gnt_vld && (gnt_port == 1'b0);
    assign req1_ready = !reset && gnt_vld && (gnt_port == 1'b1);

    // Operand mux into the single shifter instance.
    assign sh_in  = gnt_port ? req1_data  : req0_data;
    assign sh_amt = gnt_port ? req1_shamt : req0_shamt;

    LSR_64 u_lsr (
        .in     (sh_in),
        .enable (sh_amt),
        .out    (sh_out)
    );

    // Next state: load on grant, otherwise drop valid on drain; data/port hold.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_port_d  = rsp_port_q;
        prio_d      = prio_q;
        if (gnt_vld) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = sh_out;
            rsp_port_d  = gnt_port;
            prio_d      = !gnt_port;
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // State register; reset discards any pending result immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 64'd0;
            rsp_port_q  <= 1'b0;
            prio_q      <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_port_q  <= rsp_port_d;
            prio_q      <= prio_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_port  = rsp_port_q;
endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: directed vectors, a transaction-level model
// checked every cycle, and literal expectations at key points.
module tb_shift_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [63:0] req0_data, req1_data;
    logic [5:0]  req0_shamt, req1_shamt;
    logic        req0_ready, req1_ready;
    logic        rsp_valid, rsp_port, rsp_ready;
    logic [63:0] rsp_data;

    int checks   = 0;
    int failures = 0;

    shift_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_shamt (req0_shamt),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_shamt (req1_shamt),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_port   (rsp_port),
        .rsp_ready  (rsp_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    logic        m_valid, m_port, m_prio;
    logic [63:0] m_data;
    logic        e_take, e_port;

    // Who should be served this cycle, from the arbitration rules.
    always_comb begin
        e_take = 1'b0;
        e_port = 1'b0;
        if ((!m_valid || rsp_ready) && (req0_valid || req1_valid)) begin
            e_take = 1'b1;
            e_port = (req0_valid && req1_valid) ? m_prio : req1_valid;
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_data  <= 64'd0;
            m_port  <= 1'b0;
            m_prio  <= 1'b0;
        end else if (e_take) begin
            m_valid <= 1'b1;
            m_port  <= e_port;
            m_prio  <= !e_port;
            m_data  <= e_port ? (req1_data >> req1_shamt) : (req0_data >> req0_shamt);
        end else if (m_valid && rsp_ready) begin
            m_valid <= 1'b0;
        end
    end

    // Compare DUT with model every cycle, away from the active edge.
    always @(negedge clk) begin
        chk("m_ready0",  req0_ready, !reset && e_take && !e_port);
        chk("m_ready1",  req1_ready, !reset && e_take &&  e_port);
        chk("m_rspval",  rsp_valid,  m_valid);
        chk("m_rspdata", rsp_data,   m_data);
        chk("m_rspport", rsp_port,   m_port);
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    logic [63:0] ones;

    initial begin
        ones       = 64'hFFFF_FFFF_FFFF_FFFF;
        reset      = 1'b1;
        req0_valid = 1'b1;  // readys must stay low under reset even with requests
        req1_valid = 1'b1;
        req0_data  = 64'd0;
        req1_data  = 64'd0;
        req0_shamt = 6'd0;
        req1_shamt = 6'd0;
        rsp_ready  = 1'b1;
        at_neg();
        chk("rst_valid", rsp_valid, 1'b0);
        chk("rst_data",  rsp_data,  64'd0);
        chk("rst_r0",    req0_ready, 1'b0);
        chk("rst_r1",    req1_ready, 1'b0);
        tick();

        // Test 1: single request, latency one cycle.
        reset      = 1'b0;
        req1_valid = 1'b0;
        req0_data  = 64'hF000_0000_0000_0001;
        req0_shamt = 6'd4;
        at_neg();
        chk("t1_ready0", req0_ready, 1'b1);
        tick();
        req0_valid = 1'b0;
        at_neg();
        chk("t1_valid", rsp_valid, 1'b1);
        chk("t1_port",  rsp_port,  1'b0);
        chk("t1_data",  rsp_data,  64'h0F00_0000_0000_0000);

        // Test 2: ties alternate starting at port 0 after a fresh reset.
        reset = 1'b1;
        tick();
        reset      = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_data  = 64'h8000_0000_0000_0000;
        req1_data  = 64'h8000_0000_0000_0000;
        req0_shamt = 6'd0;
        req1_shamt = 6'd63;
        for (int i = 0; i < 6; i++) begin
            at_neg();
            chk("t2_gnt0", req0_ready, (i % 2) == 0);
            chk("t2_gnt1", req1_ready, (i % 2) == 1);
            if (i > 0)
                chk("t2_data", rsp_data, ((i - 1) % 2 == 0) ? 64'h8000_0000_0000_0000 : 64'h1);
            tick();
        end

        // Test 3: backpressure for three cycles, then drain plus grant.
        rsp_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            at_neg();
            chk("t3_r0",   req0_ready, 1'b0);
            chk("t3_r1",   req1_ready, 1'b0);
            chk("t3_val",  rsp_valid,  1'b1);
            chk("t3_data", rsp_data,   64'h1);
            tick();
        end
        rsp_ready = 1'b1;
        at_neg();
        chk("t3_drain_r0", req0_ready, 1'b1);
        tick();
        at_neg();
        chk("t3_val2",  rsp_valid, 1'b1);
        chk("t3_port2", rsp_port,  1'b0);
        chk("t3_data2", rsp_data,  64'h8000_0000_0000_0000);

        // Test 4: shamt sweep on port 1.
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        req1_data  = ones;
        for (int i = 0; i < 64; i++) begin
            req1_shamt = 6'(i);
            at_neg();
            chk("t4_r1", req1_ready, 1'b1);
            if (i > 0) begin
                chk("t4_data", rsp_data, ones >> (i - 1));
                chk("t4_port", rsp_port, 1'b1);
            end
            tick();
        end
        at_neg();
        chk("t4_last", rsp_data, 64'h1);
        req1_valid = 1'b0;
        tick();

        // Test 5: asynchronous reset with a pending result and prio=1.
        req0_valid = 1'b1;
        req0_data  = 64'h1234;
        req0_shamt = 6'd0;
        rsp_ready  = 1'b0;
        tick();
        req0_valid = 1'b0;
        at_neg();
        chk("t5_pending", rsp_valid, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("t5_async_val", rsp_valid, 1'b0);
        chk("t5_async_r0",  req0_ready, 1'b0);
        @(posedge clk);
        #1;
        reset      = 1'b0;
        rsp_ready  = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req1_data  = 64'hABCD;
        req1_shamt = 6'd4;
        at_neg();
        chk("t5_tie_r0", req0_ready, 1'b1);
        chk("t5_tie_r1", req1_ready, 1'b0);
        tick();

        // Test 6: lone port 1 keeps winning, then port 0 takes the tie.
        req0_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            at_neg();
            chk("t6_solo_r1", req1_ready, 1'b1);
            tick();
        end
        req0_valid = 1'b1;
        at_neg();
        chk("t6_join_r0", req0_ready, 1'b1);
        tick();
        at_neg();
        chk("t6_next_r1", req1_ready, 1'b1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
